// File: rtl/seven_seg_pkg.sv
// Shared BCD types and helpers for the seven-segment digit path.
// BCD_DOWN_EN adds the decrement helper used by the down-count path.
package seven_seg_pkg;

    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [3:0] BCD_MIN = 4'd0;

    typedef logic [3:0] bcd_t;

    // Out-of-range codes collapse to zero so the decoder never sees 10-15.
    function automatic bcd_t bcd_clamp(input logic [3:0] v);
        return (v > BCD_MAX) ? BCD_MIN : v;
    endfunction

    function automatic bcd_t bcd_inc(input bcd_t v);
        return (v == BCD_MAX) ? BCD_MIN : v + 4'd1;
    endfunction

`ifdef BCD_DOWN_EN
    function automatic bcd_t bcd_dec(input bcd_t v);
        return (v == BCD_MIN) ? BCD_MAX : v - 4'd1;
    endfunction
`endif

endpackage

// File: rtl/bcd_digit_counter_if.sv
// Control/output bundle between a digit counter and its driver/decoder.
// BCD_DOWN_EN adds the up direction signal.
interface bcd_digit_counter_if;
    import seven_seg_pkg::*;

    logic en;
    logic load;
    bcd_t load_val;
`ifdef BCD_DOWN_EN
    logic up;
`endif
    logic W, X, Y, Z;
    logic tick;
    logic carry;

`ifdef BCD_DOWN_EN
    modport master (output en, load, load_val, up, input W, X, Y, Z, tick, carry);
    modport slave  (input en, load, load_val, up, output W, X, Y, Z, tick, carry);
`else
    modport master (output en, load, load_val, input W, X, Y, Z, tick, carry);
    modport slave  (input en, load, load_val, output W, X, Y, Z, tick, carry);
`endif

endinterface

// File: rtl/tick_prescaler.sv
// Divides enabled cycles by PRESCALE; step is high on the last enabled cycle
// of each prescale period unless clr (load) overrides it.
module tick_prescaler #(
    parameter int PRESCALE = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic step
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pcnt_d, pcnt_q;

    assign step = en && !clr && (pcnt_q == LAST);

    always_comb begin
        pcnt_d = pcnt_q;
        if (clr)
            pcnt_d = '0;
        else if (en)
            pcnt_d = (pcnt_q == LAST) ? '0 : pcnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pcnt_q <= '0;
        else        pcnt_q <= pcnt_d;
    end

endmodule

// File: rtl/bcd_digit_counter.sv
// Single BCD digit with prescaled stepping, load, tick and chain carry.
// BCD_DOWN_EN enables down counting via bus.up.
module bcd_digit_counter
    import seven_seg_pkg::*;
#(
    parameter int PRESCALE = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    bcd_digit_counter_if.slave  bus
);

    logic step;
    bcd_t cnt_d, cnt_q;
    logic tick_d, tick_q;
    logic carry_d, carry_q;

    tick_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (bus.en),
        .clr   (bus.load),
        .step  (step)
    );

    // step is already masked by load inside the prescaler, so load wins.
    always_comb begin
        cnt_d   = cnt_q;
        tick_d  = 1'b0;
        carry_d = 1'b0;
        if (bus.load) begin
            cnt_d = bcd_clamp(bus.load_val);
        end else if (step) begin
            tick_d = 1'b1;
`ifdef BCD_DOWN_EN
            if (!bus.up) begin
                cnt_d   = bcd_dec(cnt_q);
                carry_d = (cnt_q == BCD_MIN);
            end else
`endif
            begin
                cnt_d   = bcd_inc(cnt_q);
                carry_d = (cnt_q == BCD_MAX);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= BCD_MIN;
            tick_q  <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            tick_q  <= tick_d;
            carry_q <= carry_d;
        end
    end

    assign {bus.W, bus.X, bus.Y, bus.Z} = cnt_q;
    assign bus.tick  = tick_q;
    assign bus.carry = carry_q;

endmodule

// File: tb/tb_bcd_digit_counter.sv
// Scoreboard bench: two digits (PRESCALE 4 and 1) share stimulus; a
// behavioural model queues expected {WXYZ,tick,carry} per edge.
module tb_bcd_digit_counter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    logic load = 1'b0;
    logic [3:0] load_val = 4'd0;
    logic up = 1'b1;

    int checks = 0;
    int failures = 0;

    bcd_digit_counter_if if0 ();
    bcd_digit_counter_if if1 ();

    assign if0.en = en;  assign if0.load = load;  assign if0.load_val = load_val;
    assign if1.en = en;  assign if1.load = load;  assign if1.load_val = load_val;
`ifdef BCD_DOWN_EN
    assign if0.up = up;
    assign if1.up = up;
`endif

    bcd_digit_counter #(.PRESCALE(4)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    bcd_digit_counter #(.PRESCALE(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

    always #5 clk = ~clk;

    // Reference model: digit as plain integer, prescale as enabled-cycle count.
    int ps [2] = '{4, 1};
    int pc [2];
    int dg [2];
    bit tk [2];
    bit cy [2];
    logic [5:0] q0 [$];
    logic [5:0] q1 [$];

    always @(posedge clk) begin
        bit dir_up;
`ifdef BCD_DOWN_EN
        dir_up = up;
`else
        dir_up = 1'b1;
`endif
        for (int k = 0; k < 2; k++) begin
            tk[k] = 1'b0;
            cy[k] = 1'b0;
            if (!rst_n) begin
                pc[k] = 0;
                dg[k] = 0;
            end else if (load) begin
                dg[k] = (int'(load_val) > 9) ? 0 : int'(load_val);
                pc[k] = 0;
            end else if (en) begin
                pc[k] = pc[k] + 1;
                if (pc[k] == ps[k]) begin
                    pc[k] = 0;
                    tk[k] = 1'b1;
                    if (dir_up) begin
                        dg[k] = (dg[k] + 1) % 10;
                        cy[k] = (dg[k] == 0);
                    end else begin
                        dg[k] = (dg[k] + 9) % 10;
                        cy[k] = (dg[k] == 9);
                    end
                end
            end
            if (k == 0) q0.push_back({4'(dg[k]), tk[k], cy[k]});
            else        q1.push_back({4'(dg[k]), tk[k], cy[k]});
        end
    end

    task automatic check6(input string name, input logic [5:0] act, input logic [5:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got wxyz=%b tick=%b carry=%b expected wxyz=%b tick=%b carry=%b at %0t",
                     name, act[5:2], act[1], act[0], exp[5:2], exp[1], exp[0], $time);
        end
    endtask

    // Monitor: outputs are presented every cycle, sampled 1 time unit after the edge.
    always @(posedge clk) begin
        #1;
        if (q0.size() == 0 || q1.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_empty got q0=%0d q1=%0d expected nonzero", q0.size(), q1.size());
        end else begin
            check6("dut_p4", {if0.W, if0.X, if0.Y, if0.Z, if0.tick, if0.carry}, q0.pop_front());
            check6("dut_p1", {if1.W, if1.X, if1.Y, if1.Z, if1.tick, if1.carry}, q1.pop_front());
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // Reset held across a few edges: model expects all zeros.
        cycles(3);
        rst_n = 1'b1;
        en = 1'b1;
        // 0..9..0 wrap for the PRESCALE=4 digit, then en gap at pcnt=2.
        cycles(42);
        en = 1'b0;
        cycles(7);
        en = 1'b1;
        cycles(5);
        // Load 7, then load 12 (clamps to 0).
        load = 1'b1; load_val = 4'd7;
        cycles(1);
        load = 1'b0;
        cycles(6);
        load = 1'b1; load_val = 4'd12;
        cycles(1);
        load = 1'b0;
        // Load on a step edge: pcnt reaches 3 after three enabled cycles.
        cycles(3);
        load = 1'b1; load_val = 4'd3;
        cycles(1);
        load = 1'b0;
        cycles(4);
`ifdef BCD_DOWN_EN
        load = 1'b1; load_val = 4'd0;
        cycles(1);
        load = 1'b0;
        up = 1'b0;
        cycles(30);
        up = 1'b1;
`endif
        // Load 5 then assert async reset between edges.
        load = 1'b1; load_val = 4'd5;
        cycles(1);
        load = 1'b0;
        cycles(2);
        #2;
        rst_n = 1'b0;
        #1;
        check6("async_rst_p4", {if0.W, if0.X, if0.Y, if0.Z, if0.tick, if0.carry}, 6'b0);
        check6("async_rst_p1", {if1.W, if1.X, if1.Y, if1.Z, if1.tick, if1.carry}, 6'b0);
        cycles(2);
        rst_n = 1'b1;
        // Randomized phase.
        for (int i = 0; i < 800; i++) begin
            en = ($urandom_range(0, 9) < 8);
            load = ($urandom_range(0, 19) == 0);
            load_val = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 24) == 0) up = ~up;
            cycles(1);
        end
        load = 1'b0;
        cycles(3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/bcd_digit_counter.md
# bcd_digit_counter

Single-digit BCD counter that generates the 4-bit code driven into the `SevenSegment` decoder (W, X, Y, Z). It sits directly upstream of the decoder. A programmable prescaler paces the count, and a carry pulse allows several digits to be chained. Outputs are fully registered, so the decoder sees glitch-free codes 0–9 only.

## Interface
- `PRESCALE`, default 4: enabled clock cycles per count step. Legal range is ≥1; 1 means one step per enabled cycle.
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: reset, asynchronous and active-low.
- `en` input 1: count enable. Low freezes the prescaler and the digit.
- `load` input 1: synchronous load strobe.
- `load_val` input 4: value to load.
- `up` input 1: direction, 1 = up, 0 = down. Present only with `BCD_DOWN_EN`.
- `W` output 1: BCD bit 3 (MSB).
- `X` output 1: BCD bit 2.
- `Y` output 1: BCD bit 1.
- `Z` output 1: BCD bit 0 (LSB).
- `tick` output 1: one-cycle pulse, registered, coincident with every count step.
- `carry` output 1: one-cycle pulse, registered, coincident with a wrap step.

## Operation
- Internal state:
  - prescaler `pcnt`, width max(1, $clog2(PRESCALE)), range 0..PRESCALE-1;
  - digit `cnt[3:0]`, range 0..9;
  - `{W,X,Y,Z} = cnt`.
- Reset, asynchronous on `rst_n` low, takes effect immediately regardless of clock: `cnt=0`, `pcnt=0`, `tick=0`, `carry=0`, so WXYZ=0000.
- Priority per rising edge: `load` > `en` > hold.
- Load:
  - `cnt <= load_val` if ≤9; load_val 10–15 loads 0;
  - `pcnt <= 0`;
  - `tick=0`, `carry=0` next cycle;
  - `en` is ignored that cycle.
- Enabled with `pcnt < PRESCALE-1`: `pcnt++`, `cnt` holds, `tick=0`, `carry=0`.
- Enabled with `pcnt == PRESCALE-1` (step edge): `pcnt <= 0`, `tick <= 1`, and:
  - up: `cnt <= (cnt==9) ? 0 : cnt+1`, with `carry <= (cnt==9)`;
  - down: `cnt <= (cnt==0) ? 9 : cnt-1`, with `carry <= (cnt==0)`.
- `en` low: `pcnt` and `cnt` hold; `tick=0`, `carry=0` next cycle.
- Direction change mid-prescale takes effect at the next step edge. `pcnt` is not cleared.
- `cnt` never holds 10–15. Increment and decrement are explicit BCD operations, not binary wrap at 15.

## Timing
- From `rst_n` deasserted with `en` held high, the first step edge is the PRESCALE-th rising edge. WXYZ changes on that edge.
- Full digit period (0→0) is 10·PRESCALE enabled cycles. `carry` asserts once per period.
- `tick` and `carry` are high exactly in the cycle after the step edge, aligned with the new WXYZ value.
- Load-to-output latency is 1 cycle. The next step comes PRESCALE enabled cycles after the load.
- `load` and a step edge on the same cycle: the load wins and no tick or carry is produced.
- `rst_n` asserted mid-prescale: the partial prescale count is discarded, and counting restarts from a full PRESCALE after release.

## Configuration
- Macro: `BCD_DOWN_EN`.
- Defined: the `up` port exists and up/down counting applies as above.
- Undefined: the `up` port is absent, the counter is up-only, and there is no down-count logic.

## Structure
- Shared package `seven_seg_pkg` holds:
  - `BCD_MAX = 4'd9`, `BCD_MIN = 4'd0`;
  - typedef `bcd_t` (logic [3:0]).
- One natural sub-module: `tick_prescaler`.
  - Contains `pcnt`.
  - Parameter PRESCALE.
  - Inputs: `clk`, `rst_n`, `en`, `clr` (from `load`).
  - Output: combinational `step` pulse.
- `bcd_digit_counter` owns `cnt`, `tick` and `carry`.

## Test plan
- Reset and up-count, PRESCALE=4, `en`=1:
  - release `rst_n` → WXYZ=0000 until edge 4, then 0001;
  - 9→0 step after 40 edges, with `carry`=1 for exactly one cycle alongside WXYZ=0000.
- Enable gating: drop `en` for 7 cycles at `pcnt`=2 → WXYZ, `tick` and `carry` frozen. The step occurs 2 enabled cycles after `en` returns.
- Load:
  - `load_val`=7 → WXYZ=0111 next cycle, next step to 1000 after 4 enabled cycles;
  - `load_val`=12 → WXYZ=0000;
  - `load` coincident with a step edge → no tick.
- Down count, `BCD_DOWN_EN` defined, `up`=0 from 0 → first step gives 9 (1001) with `carry`=1, then 8, 7, …
- Async reset mid-operation: assert `rst_n` low between clock edges at count 5 → WXYZ=0000 immediately with no clock edge. `tick` and `carry` read 0.
- PRESCALE=1: WXYZ steps every enabled cycle 0..9,0, with `tick` continuously 1 while `en`=1.
